// File: rtl/eth_crc_pkg.sv
// Shared Ethernet CRC-32 constants, FSM state type and the byte-serial step function.
// The step function is shared with the RX FCS checker.
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_READ = 2'd2
  } crc_state_t;

  // Reflected CRC-32 over one byte, LSB first: eight unrolled shift/xor steps.
  function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_gen_chk.sv
// Simulation checker for eth_crc32_gen: flags a frame byte offered in the same
// enabled cycle as an FCS read (the read wins and the byte is dropped).
module eth_crc32_gen_chk (
  input logic clk_i,
  input logic rst_n_i,
  input logic clk_en_i,
  input logic Data_en,
  input logic CRC_rd
);

  a_no_data_during_read: assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
    clk_en_i |-> !(Data_en && CRC_rd)
  );

endmodule

// File: rtl/eth_crc32_gen.sv
// Ethernet FCS generator for the GMII TX path: folds frame bytes into a CRC-32 and
// serves the four FCS bytes on request. Optional macro ETH_CRC_ERR_INJECT_EN adds a bad-FCS injector.
module eth_crc32_gen
  import eth_crc_pkg::*;
#(
  parameter int BYTE_CNT_WIDTH = 14
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      clk_en_i,
  input  logic                      CRC_init,
  input  logic                      Data_en,
  input  logic [7:0]                Frame_data,
  input  logic                      CRC_rd,
`ifdef ETH_CRC_ERR_INJECT_EN
  input  logic                      crc_err_inject_i,
`endif
  output logic                      CRC_end,
  output logic [7:0]                CRC_out,
  output logic [BYTE_CNT_WIDTH-1:0] frame_len_o
);

  crc_state_t                r_state;
  logic [31:0]               r_crc;
  logic [1:0]                r_rd_cnt;
  logic [BYTE_CNT_WIDTH-1:0] r_len;
  logic [7:0]                w_fcs_byte;
  logic                      w_flip;
  logic                      w_len_sat;

`ifdef ETH_CRC_ERR_INJECT_EN
  logic r_err;
  assign w_flip = r_err & (r_rd_cnt == 2'd3);
`else
  assign w_flip = 1'b0;
`endif

  assign w_len_sat   = &r_len;
  assign frame_len_o = r_len;

  // FCS byte mux: zero-latency, and a quiet all-zero bus when no byte is requested.
  always_comb begin
    w_fcs_byte = ~r_crc[{r_rd_cnt, 3'b000} +: 8] ^ {8{w_flip}};
    CRC_out    = CRC_rd ? w_fcs_byte : 8'h00;
    CRC_end    = CRC_rd & (r_rd_cnt == 2'd3);
  end

  // Frame FSM, CRC register, read pointer and saturating length counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_crc    <= CRC32_INIT;
      r_rd_cnt <= 2'd0;
      r_len    <= '0;
`ifdef ETH_CRC_ERR_INJECT_EN
      r_err    <= 1'b0;
`endif
    end else if (clk_en_i) begin
      if (CRC_init) begin
        // Restart is legal from any state, including mid-frame.
        r_state  <= ST_CALC;
        r_crc    <= CRC32_INIT;
        r_rd_cnt <= 2'd0;
        r_len    <= '0;
`ifdef ETH_CRC_ERR_INJECT_EN
        r_err    <= crc_err_inject_i;
`endif
      end else begin
        if (CRC_rd) begin
          r_rd_cnt <= r_rd_cnt + 2'd1;
        end
`ifdef ETH_CRC_ERR_INJECT_EN
        if (CRC_end) begin
          r_err <= 1'b0;
        end
`endif
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_CALC: begin
            if (CRC_rd) begin
              r_state <= ST_READ;
            end else if (Data_en) begin
              r_crc <= crc32_byte_step(r_crc, Frame_data);
              if (!w_len_sat) begin
                r_len <= r_len + {{(BYTE_CNT_WIDTH-1){1'b0}}, 1'b1};
              end
            end
          end
          ST_READ: begin
            if (CRC_end) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_crc32_gen.sv
// Self-checking bench for eth_crc32_gen: directed frames plus random frames checked
// against a bit-serial CRC-32 reference. Define ETH_CRC_ERR_INJECT_EN to cover the injector.
module tb_eth_crc32_gen;
  localparam int W = 14;

  logic         clk_i = 1'b0;
  logic         rst_n_i, clk_en_i, CRC_init, Data_en, CRC_rd;
  logic [7:0]   Frame_data;
  logic         CRC_end;
  logic [7:0]   CRC_out;
  logic [W-1:0] frame_len_o;
`ifdef ETH_CRC_ERR_INJECT_EN
  logic         crc_err_inject_i;
  localparam bit HAS_INJ = 1'b1;
`else
  localparam bit HAS_INJ = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  eth_crc32_gen #(.BYTE_CNT_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .CRC_init(CRC_init),
    .Data_en(Data_en), .Frame_data(Frame_data), .CRC_rd(CRC_rd),
`ifdef ETH_CRC_ERR_INJECT_EN
    .crc_err_inject_i(crc_err_inject_i),
`endif
    .CRC_end(CRC_end), .CRC_out(CRC_out), .frame_len_o(frame_len_o)
  );

  eth_crc32_gen_chk u_chk (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i),
    .Data_en(Data_en), .CRC_rd(CRC_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference FCS: bit-at-a-time Galois LFSR over the whole message, final complement.
  function automatic logic [31:0] model_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic cyc(input int div);
    for (int k = 0; k < div; k++) begin
      clk_en_i = (k == div - 1);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] q[$], input int div,
                           input logic inj, input logic [31:0] exp_fcs);
    logic [31:0] e;
    int          exp_len;
    e = exp_fcs;
    if (inj && HAS_INJ) e[31:24] = ~e[31:24];
`ifdef ETH_CRC_ERR_INJECT_EN
    crc_err_inject_i = inj;
`endif
    CRC_init = 1'b1;
    cyc(div);
    CRC_init = 1'b0;
`ifdef ETH_CRC_ERR_INJECT_EN
    crc_err_inject_i = 1'b0;
`endif
    foreach (q[i]) begin
      Data_en    = 1'b1;
      Frame_data = q[i];
      cyc(div);
    end
    Data_en    = 1'b0;
    Frame_data = 8'h00;
    exp_len    = (q.size() > (2**W - 1)) ? (2**W - 1) : q.size();
    #1;
    chk({tag, "_len"}, 32'(frame_len_o), exp_len);
    chk({tag, "_out_idle"}, 32'(CRC_out), 32'h0);
    chk({tag, "_end_idle"}, 32'(CRC_end), 32'h0);
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) begin
      CRC_rd = 1'b1;
      for (int k = 0; k < div; k++) begin
        clk_en_i = (k == div - 1);
        #2;
        chk($sformatf("%s_fcs%0d", tag, i), 32'(CRC_out), 32'(e[8*i +: 8]));
        chk($sformatf("%s_end%0d", tag, i), 32'(CRC_end), (i == 3) ? 32'h1 : 32'h0);
        @(posedge clk_i); #1;
      end
    end
    CRC_rd   = 1'b0;
    clk_en_i = 1'b1;
  endtask

  initial begin
    logic [7:0]  s123[$];
    logic [7:0]  q[$];
    logic [7:0]  q2[$];
    logic [31:0] f;
    int          n;

    s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst_n_i = 1'b0; clk_en_i = 1'b1; CRC_init = 1'b0; Data_en = 1'b0;
    CRC_rd = 1'b0; Frame_data = 8'h00;
`ifdef ETH_CRC_ERR_INJECT_EN
    crc_err_inject_i = 1'b0;
`endif
    #23;
    chk("rst_len", 32'(frame_len_o), 32'h0);
    chk("rst_out", 32'(CRC_out), 32'h0);
    chk("rst_end", 32'(CRC_end), 32'h0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Check value of "123456789", then data while idle must be ignored.
    run_frame("t1", s123, 1, 1'b0, 32'hCBF4_3926);
    Data_en = 1'b1; Frame_data = 8'hA5;
    cyc(1); cyc(1); cyc(1);
    Data_en = 1'b0;
    chk("idle_data_len", 32'(frame_len_o), 32'd9);

    // Minimum frame, then frame+FCS must leave the magic residue.
    q.delete();
    for (int i = 0; i < 14; i++) q.push_back(8'($urandom_range(255, 0)));
    for (int i = 0; i < 46; i++) q.push_back(8'h00);
    f = model_fcs(q);
    run_frame("t2", q, 1, 1'b0, f);
    q2 = q;
    for (int i = 0; i < 4; i++) q2.push_back(f[8*i +: 8]);
    run_frame("t2res", q2, 1, 1'b0, ~32'hDEBB_20E3);

    // MII-rate clock enable.
    run_frame("t3", s123, 10, 1'b0, 32'hCBF4_3926);

    // Restart mid-frame.
    CRC_init = 1'b1; cyc(1); CRC_init = 1'b0;
    for (int i = 0; i < 20; i++) begin
      Data_en = 1'b1; Frame_data = 8'($urandom_range(255, 0)); cyc(1);
    end
    Data_en = 1'b0;
    run_frame("t4", s123, 1, 1'b0, 32'hCBF4_3926);

    // Async reset in the middle of the FCS read.
    CRC_init = 1'b1; cyc(1); CRC_init = 1'b0;
    foreach (s123[i]) begin
      Data_en = 1'b1; Frame_data = s123[i]; cyc(1);
    end
    Data_en = 1'b0; Frame_data = 8'h00;
    CRC_rd = 1'b1; cyc(1);
    #1;
    chk("t5_byte1", 32'(CRC_out), 32'h39);
    rst_n_i = 1'b0;
    #1;
    chk("t5_rst_out", 32'(CRC_out), 32'h0);
    chk("t5_rst_end", 32'(CRC_end), 32'h0);
    chk("t5_rst_len", 32'(frame_len_o), 32'h0);
    CRC_rd = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    Data_en = 1'b1; Frame_data = 8'h5A;
    cyc(1); cyc(1);
    Data_en = 1'b0;
    chk("t5_idle_len", 32'(frame_len_o), 32'h0);
    run_frame("t5next", s123, 1, 1'b0, 32'hCBF4_3926);

    // Random frames at random enable rates.
    for (int r = 0; r < 4; r++) begin
      q.delete();
      n = $urandom_range(64, 1);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255, 0)));
      run_frame($sformatf("rnd%0d", r), q, $urandom_range(3, 1), 1'b0, model_fcs(q));
    end

    // Length counter saturation on an oversized frame.
    q.delete();
    for (int i = 0; i < 16390; i++) q.push_back(8'($urandom_range(255, 0)));
    run_frame("sat", q, 1, 1'b0, model_fcs(q));

`ifdef ETH_CRC_ERR_INJECT_EN
    run_frame("t6inj", s123, 1, 1'b1, 32'hCBF4_3926);
    run_frame("t6clean", s123, 1, 1'b0, 32'hCBF4_3926);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
